// File: rtl/ppu_arbiter.sv
// ppu_arbiter: round-robin front end sharing one ppu_top among NREQ requesters;
// results are routed back in issue order through a tag FIFO. Optional grant lock: PPU_ARB_LOCK_EN.
module ppu_arbiter #(
   parameter int NREQ  = 4,
   parameter int WORD  = 32,
   parameter int OPW   = 3,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [NREQ*WORD-1:0]     req_operand1_i,
   input  logic [NREQ*WORD-1:0]     req_operand2_i,
   input  logic [NREQ*WORD-1:0]     req_operand3_i,
   input  logic [NREQ*OPW-1:0]      req_op_i,
`ifdef PPU_ARB_LOCK_EN
   input  logic [NREQ-1:0]          req_lock_i,
`endif
   output logic                     ppu_in_valid_o,
   output logic [WORD-1:0]          ppu_operand1_o,
   output logic [WORD-1:0]          ppu_operand2_o,
   output logic [WORD-1:0]          ppu_operand3_o,
   output logic [OPW-1:0]           ppu_op_o,
   input  logic [WORD-1:0]          ppu_result_i,
   input  logic                     ppu_out_valid_i,
   output logic [NREQ-1:0]          rsp_valid_o,
   output logic [WORD-1:0]          rsp_result_o,
   output logic [$clog2(DEPTH):0]   inflight_o,
   output logic                     err_o
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
      onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   logic [WORD-1:0] op1_a_s [NREQ];
   logic [WORD-1:0] op2_a_s [NREQ];
   logic [WORD-1:0] op3_a_s [NREQ];
   logic [OPW-1:0]  opc_a_s [NREQ];

   logic [IDXW-1:0] rr_ptr_r;
   logic [IDXW-1:0] sel_idx_s;
   logic            found_s;
   logic [NREQ-1:0] req_ready_s;
   logic            accept_s;
   logic            pop_s;
   logic [IDXW-1:0] tag_mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   inflight_r;
   logic            err_r;
   logic            ppu_in_valid_r;
   logic [WORD-1:0] ppu_operand1_r;
   logic [WORD-1:0] ppu_operand2_r;
   logic [WORD-1:0] ppu_operand3_r;
   logic [OPW-1:0]  ppu_op_r;
`ifdef PPU_ARB_LOCK_EN
   logic            lock_vld_r;
`endif

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign op1_a_s[k] = req_operand1_i[k*WORD +: WORD];
      assign op2_a_s[k] = req_operand2_i[k*WORD +: WORD];
      assign op3_a_s[k] = req_operand3_i[k*WORD +: WORD];
      assign opc_a_s[k] = req_op_i[k*OPW +: OPW];
   end

   // Requester selection: a held lock keeps the last grant, else search after rr_ptr_r with wrap.
   always_comb begin
      found_s   = 1'b0;
      sel_idx_s = rr_ptr_r;
`ifdef PPU_ARB_LOCK_EN
      if (lock_vld_r && req_lock_i[rr_ptr_r] && req_valid_i[rr_ptr_r]) begin
         found_s = 1'b1;
      end else begin
         found_s = 1'b0;
      end
`endif
      for (int i = 1; i <= NREQ; i++) begin
         if (!found_s && req_valid_i[IDXW'((int'(rr_ptr_r) + i) % NREQ)]) begin
            found_s   = 1'b1;
            sel_idx_s = IDXW'((int'(rr_ptr_r) + i) % NREQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant only with FIFO room; deliberately blind to ppu_out_valid_i.
   always_comb begin
      req_ready_s = {NREQ{1'b0}};
      if (rst_i && found_s && (inflight_r < CW'(DEPTH))) begin
         req_ready_s = onehot(sel_idx_s);
      end else begin
         req_ready_s = {NREQ{1'b0}};
      end
   end

   assign accept_s = |req_ready_s;
   assign pop_s    = rst_i && ppu_out_valid_i && (inflight_r != {CW{1'b0}});

   // Zero-latency response steering from the FIFO head tag.
   always_comb begin
      rsp_valid_o = {NREQ{1'b0}};
      if (pop_s) begin
         rsp_valid_o = onehot(tag_mem_r[rd_ptr_r]);
      end else begin
         rsp_valid_o = {NREQ{1'b0}};
      end
   end

   // Tag storage needs no reset; pointers and count define its content.
   always_ff @(posedge clk_i) begin
      if (accept_s) begin
         tag_mem_r[wr_ptr_r] <= sel_idx_s;
      end
   end

   // Issue register, round-robin pointer, FIFO bookkeeping and sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rr_ptr_r       <= IDXW'(NREQ-1);
         ppu_in_valid_r <= 1'b0;
         ppu_operand1_r <= {WORD{1'b0}};
         ppu_operand2_r <= {WORD{1'b0}};
         ppu_operand3_r <= {WORD{1'b0}};
         ppu_op_r       <= {OPW{1'b0}};
         wr_ptr_r       <= {PW{1'b0}};
         rd_ptr_r       <= {PW{1'b0}};
         inflight_r     <= {CW{1'b0}};
         err_r          <= 1'b0;
`ifdef PPU_ARB_LOCK_EN
         lock_vld_r     <= 1'b0;
`endif
      end else begin
         if (accept_s) begin
            rr_ptr_r       <= sel_idx_s;
            ppu_in_valid_r <= 1'b1;
            ppu_operand1_r <= op1_a_s[sel_idx_s];
            ppu_operand2_r <= op2_a_s[sel_idx_s];
            ppu_operand3_r <= op3_a_s[sel_idx_s];
            ppu_op_r       <= opc_a_s[sel_idx_s];
            wr_ptr_r       <= wr_ptr_r + 1'b1;
`ifdef PPU_ARB_LOCK_EN
            lock_vld_r     <= 1'b1;
`endif
         end else begin
            ppu_in_valid_r <= 1'b0;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({accept_s, pop_s})
            2'b10:   inflight_r <= inflight_r + 1'b1;
            2'b01:   inflight_r <= inflight_r - 1'b1;
            default: inflight_r <= inflight_r;
         endcase
         if (ppu_out_valid_i && (inflight_r == {CW{1'b0}})) begin
            err_r <= 1'b1;
         end
      end
   end

   assign req_ready_o    = req_ready_s;
   assign ppu_in_valid_o = ppu_in_valid_r;
   assign ppu_operand1_o = ppu_operand1_r;
   assign ppu_operand2_o = ppu_operand2_r;
   assign ppu_operand3_o = ppu_operand3_r;
   assign ppu_op_o       = ppu_op_r;
   assign rsp_result_o   = ppu_result_i;
   assign inflight_o     = inflight_r;
   assign err_o          = err_r;

endmodule
